// File: rtl/spart_pkg.sv
// Shared definitions for the SPART UART core: bus register map, status bit
// positions, TX/RX state encodings and timing constants.
// Optional feature macro: SPART_PARITY_EN (adds an even parity bit to frames).
package spart_pkg;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    localparam int STAT_TBR = 0;
    localparam int STAT_RDA = 1;
    localparam int STAT_FRM = 2;
    localparam int STAT_OVR = 3;
    localparam int STAT_PAR = 4;

    localparam logic [15:0] RESET_DIVISOR = 16'h0412;

    // Ticks per bit time; the receiver samples in the middle of each bit.
    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef SPART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef SPART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud generator: holds the 16-bit divisor (DBH:DBL) and produces a one-cycle
// tick every divisor+1 clocks. A new divisor is picked up at the next reload.
module spart_baud_gen
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wrDbl,
    input  logic       i_wrDbh,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_dbl,
    output logic [7:0] o_dbh,
    output logic       o_tick
);

    logic [7:0]  r_dbl;
    logic [7:0]  r_dbh;
    logic [15:0] r_count;

    // Divisor byte registers, loaded by bus writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dbl <= RESET_DIVISOR[7:0];
            r_dbh <= RESET_DIVISOR[15:8];
        end else begin
            if (i_wrDbl) r_dbl <= i_wdata;
            if (i_wrDbh) r_dbh <= i_wdata;
        end
    end

    // Down-counter that reloads from the divisor when it reaches zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= RESET_DIVISOR;
        end else if (o_tick) begin
            r_count <= {r_dbh, r_dbl};
        end else begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_tick = (r_count == 16'd0);
    assign o_dbl  = r_dbl;
    assign o_dbh  = r_dbh;

endmodule

// File: rtl/spart_core.sv
// SPART: simple programmable UART with a 4-register bus interface, a shared
// baud generator, a transmitter and an oversampling receiver.
// Optional feature macro: SPART_PARITY_EN (even parity on TX, checked on RX).
module spart_core
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic       w_rdBuf, w_rdStatus, w_wrBuf, w_wrDbl, w_wrDbh, w_txLoad;
    logic       w_tick, w_txBitEnd, w_rxSample, w_rxDone, w_rxFall, w_parErr;
    logic [7:0] w_dbl, w_dbh, w_status, w_rdata;

    tx_state_t  r_txState, w_txNext;
    logic       r_txPend;
    logic [7:0] r_txShift;
    logic [3:0] r_txTicks;
    logic [2:0] r_txBit;

    rx_state_t  r_rxState, w_rxNext;
    logic       r_rxSync1, r_rxSync2, r_rxPrev;
    logic [3:0] r_rxTicks;
    logic [2:0] r_rxBit;
    logic [7:0] r_rxShift, r_rxBuf;
    logic       r_frmErr, r_ovrErr;
`ifdef SPART_PARITY_EN
    logic       r_txPar, r_rxPar, r_parErr;
`endif

    assign w_rdBuf    = iocs &  iorw & (ioaddr == ADDR_BUF);
    assign w_rdStatus = iocs &  iorw & (ioaddr == ADDR_STATUS);
    assign w_wrBuf    = iocs & ~iorw & (ioaddr == ADDR_BUF);
    assign w_wrDbl    = iocs & ~iorw & (ioaddr == ADDR_DBL);
    assign w_wrDbh    = iocs & ~iorw & (ioaddr == ADDR_DBH);

    spart_baud_gen u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_wrDbl(w_wrDbl),
        .i_wrDbh(w_wrDbh),
        .i_wdata(databus),
        .o_dbl  (w_dbl),
        .o_dbh  (w_dbh),
        .o_tick (w_tick)
    );

    // ---------------- transmitter ----------------
    // A byte accepted while idle waits in r_txPend until the next tick starts the frame.
    assign tbr        = (r_txState == TX_IDLE) && !r_txPend;
    assign w_txLoad   = w_wrBuf && tbr;
    assign w_txBitEnd = w_tick && (r_txTicks == LAST_TICK);

    // TX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_txState <= TX_IDLE;
        else      r_txState <= w_txNext;
    end

    // TX next-state: each bit lasts OVERSAMPLE ticks.
    always_comb begin
        w_txNext = r_txState;
        case (r_txState)
            TX_IDLE:   if (r_txPend && w_tick) w_txNext = TX_START;
            TX_START:  if (w_txBitEnd) w_txNext = TX_DATA;
`ifdef SPART_PARITY_EN
            TX_DATA:   if (w_txBitEnd && r_txBit == 3'd7) w_txNext = TX_PARITY;
            TX_PARITY: if (w_txBitEnd) w_txNext = TX_STOP;
`else
            TX_DATA:   if (w_txBitEnd && r_txBit == 3'd7) w_txNext = TX_STOP;
`endif
            TX_STOP:   if (w_txBitEnd) w_txNext = TX_IDLE;
            default:   w_txNext = TX_IDLE;
        endcase
    end

    // TX output: serial line level for the current frame position.
    always_comb begin
        txd = 1'b1;
        case (r_txState)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = r_txShift[0];
`ifdef SPART_PARITY_EN
            TX_PARITY: txd = r_txPar;
`endif
            default:   txd = 1'b1;
        endcase
    end

    // TX datapath: pending flag, shifter, tick and bit counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txPend  <= 1'b0;
            r_txShift <= 8'h00;
            r_txTicks <= 4'd0;
            r_txBit   <= 3'd0;
`ifdef SPART_PARITY_EN
            r_txPar   <= 1'b0;
`endif
        end else begin
            if (w_txLoad) begin
                r_txPend  <= 1'b1;
                r_txShift <= databus;
`ifdef SPART_PARITY_EN
                r_txPar   <= ^databus;
`endif
            end else begin
                if (r_txState == TX_IDLE && w_tick) r_txPend <= 1'b0;
                if (r_txState == TX_DATA && w_txBitEnd) r_txShift <= {1'b0, r_txShift[7:1]};
            end
            if (r_txState == TX_IDLE) r_txTicks <= 4'd0;
            else if (w_tick)          r_txTicks <= r_txTicks + 4'd1;
            if (r_txState != TX_DATA) r_txBit <= 3'd0;
            else if (w_txBitEnd)      r_txBit <= r_txBit + 3'd1;
        end
    end

    // ---------------- receiver ----------------
    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
            r_rxPrev  <= 1'b1;
        end else begin
            r_rxSync1 <= rxd;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
        end
    end

    assign w_rxFall = r_rxPrev & ~r_rxSync2;

    // RX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rxState <= RX_IDLE;
        else      r_rxState <= w_rxNext;
    end

    // RX next-state: a start bit still high at its midpoint is a false start.
    always_comb begin
        w_rxNext = r_rxState;
        case (r_rxState)
            RX_IDLE:   if (w_rxFall) w_rxNext = RX_START;
            RX_START:  if (w_rxSample) w_rxNext = r_rxSync2 ? RX_IDLE : RX_DATA;
`ifdef SPART_PARITY_EN
            RX_DATA:   if (w_rxSample && r_rxBit == 3'd7) w_rxNext = RX_PARITY;
            RX_PARITY: if (w_rxSample) w_rxNext = RX_STOP;
`else
            RX_DATA:   if (w_rxSample && r_rxBit == 3'd7) w_rxNext = RX_STOP;
`endif
            RX_STOP:   if (w_rxSample) w_rxNext = RX_IDLE;
            default:   w_rxNext = RX_IDLE;
        endcase
    end

    // RX outputs: mid-bit sample strobe and frame-complete strobe.
    always_comb begin
        w_rxSample = 1'b0;
        w_rxDone   = 1'b0;
        if (r_rxState != RX_IDLE)
            w_rxSample = w_tick && (r_rxTicks == ((r_rxState == RX_START) ? MID_TICK : LAST_TICK));
        if (r_rxState == RX_STOP)
            w_rxDone = w_rxSample;
    end

    // RX datapath: tick and bit counters, data shifter, received parity bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxTicks <= 4'd0;
            r_rxBit   <= 3'd0;
            r_rxShift <= 8'h00;
`ifdef SPART_PARITY_EN
            r_rxPar   <= 1'b0;
`endif
        end else begin
            if (r_rxState == RX_IDLE || w_rxSample) r_rxTicks <= 4'd0;
            else if (w_tick)                        r_rxTicks <= r_rxTicks + 4'd1;
            if (r_rxState != RX_DATA) r_rxBit <= 3'd0;
            else if (w_rxSample)      r_rxBit <= r_rxBit + 3'd1;
            if (r_rxState == RX_DATA && w_rxSample) r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
`ifdef SPART_PARITY_EN
            if (r_rxState == RX_PARITY && w_rxSample) r_rxPar <= r_rxSync2;
`endif
        end
    end

    // Receive buffer and flags; a completing frame or error beats a clearing read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rxBuf  <= 8'h00;
            rda      <= 1'b0;
            r_frmErr <= 1'b0;
            r_ovrErr <= 1'b0;
`ifdef SPART_PARITY_EN
            r_parErr <= 1'b0;
`endif
        end else begin
            if (w_rxDone) r_rxBuf <= r_rxShift;
            if (w_rxDone)     rda <= 1'b1;
            else if (w_rdBuf) rda <= 1'b0;
            if (w_rxDone && !r_rxSync2) r_frmErr <= 1'b1;
            else if (w_rdStatus)        r_frmErr <= 1'b0;
            if (w_rxDone && rda)  r_ovrErr <= 1'b1;
            else if (w_rdStatus)  r_ovrErr <= 1'b0;
`ifdef SPART_PARITY_EN
            if (w_rxDone && ((^r_rxShift) != r_rxPar)) r_parErr <= 1'b1;
            else if (w_rdStatus)                       r_parErr <= 1'b0;
`endif
        end
    end

    // ---------------- bus read side ----------------
`ifdef SPART_PARITY_EN
    assign w_parErr = r_parErr;
`else
    assign w_parErr = 1'b0;
`endif

    // Status byte assembly and read-data mux.
    always_comb begin
        w_status           = 8'h00;
        w_status[STAT_TBR] = tbr;
        w_status[STAT_RDA] = rda;
        w_status[STAT_FRM] = r_frmErr;
        w_status[STAT_OVR] = r_ovrErr;
        w_status[STAT_PAR] = w_parErr;
        case (ioaddr)
            ADDR_BUF:    w_rdata = r_rxBuf;
            ADDR_STATUS: w_rdata = w_status;
            ADDR_DBL:    w_rdata = w_dbl;
            default:     w_rdata = w_dbh;
        endcase
    end

    assign databus = (iocs && iorw) ? w_rdata : 8'hzz;

endmodule

// File: tb/tb_spart_core.sv
// Self-checking bench for spart_core. A frame-level transmit model (tick
// counting plus a list of frame bits) is compared against txd/tbr on every
// cycle; receive behaviour is checked through bus reads after driven frames.
// Honours SPART_PARITY_EN when it is defined for the build.
module tb_spart_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iocs = 1'b0;
    logic       iorw = 1'b1;
    logic [1:0] ioaddr = 2'b00;
    wire  [7:0] databus;
    logic [7:0] busDrive = 8'h00;
    logic       busEn = 1'b0;
    logic       rxdDrive = 1'b1;
    logic       loopBack = 1'b0;
    wire        rxd;
    logic       rda, tbr, txd;

    assign databus = busEn ? busDrive : 8'hzz;
    assign rxd     = loopBack ? txd : rxdDrive;

    spart_core dut (
        .clk    (clk),
        .rst    (rst),
        .iocs   (iocs),
        .iorw   (iorw),
        .ioaddr (ioaddr),
        .databus(databus),
        .rda    (rda),
        .tbr    (tbr),
        .txd    (txd),
        .rxd    (rxd)
    );

    always #5 clk = ~clk;

`ifdef SPART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BIT_CLKS = 64;

    int testsRun    = 0;
    int testsFailed = 0;
    bit compareOn   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transmit model: divisor countdown gives ticks, a frame is a list of bits
    // each held for 16 ticks, starting at the first tick after acceptance.
    logic [15:0] mCnt = 16'h0412;
    logic [15:0] mDiv = 16'h0412;
    logic        mTick = 1'b0;
    bit          mBusy = 1'b0;
    bit          mStarted = 1'b0;
    int          mBitIdx = 0;
    int          mTickInBit = 0;
    logic        mFrame [0:10];
    logic        mTxd = 1'b1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mCnt = 16'h0412; mDiv = 16'h0412;
            mBusy = 1'b0; mStarted = 1'b0; mBitIdx = 0; mTickInBit = 0; mTxd = 1'b1;
        end else begin
            mTick = (mCnt == 16'd0);
            mCnt  = mTick ? mDiv : mCnt - 16'd1;
            if (!mBusy) begin
                if (iocs && !iorw && ioaddr == 2'b00) begin
                    mBusy = 1'b1;
                    mStarted = 1'b0;
                    mFrame[0] = 1'b0;
                    for (int i = 0; i < 8; i++) mFrame[i + 1] = busDrive[i];
`ifdef SPART_PARITY_EN
                    mFrame[9] = ^busDrive;
`endif
                    mFrame[FRAME_BITS - 1] = 1'b1;
                end
            end else if (!mStarted) begin
                if (mTick) begin
                    mStarted = 1'b1; mBitIdx = 0; mTickInBit = 0;
                end
            end else if (mTick) begin
                mTickInBit++;
                if (mTickInBit == 16) begin
                    mTickInBit = 0;
                    mBitIdx++;
                    if (mBitIdx == FRAME_BITS) begin
                        mBusy = 1'b0; mStarted = 1'b0;
                    end
                end
            end
            if (iocs && !iorw && ioaddr == 2'b10) mDiv[7:0]  = busDrive;
            if (iocs && !iorw && ioaddr == 2'b11) mDiv[15:8] = busDrive;
            mTxd = mStarted ? mFrame[mBitIdx] : 1'b1;
        end
    end

    // Per-cycle comparison of the transmit side against the model.
    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("txd", txd, mTxd);
            checkOutput("tbr", tbr, !mBusy);
        end
    end

    // Bus write.
    task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = addr; busDrive = data; busEn = 1'b1;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1; busEn = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [7:0] data);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = addr;
        #1 data = databus;
        @(negedge clk);
        iocs = 1'b0;
    endtask

    task automatic waitTbrHigh(input int limit);
        int n = 0;
        while (tbr !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tbrReturn", tbr, 1'b1);
    endtask

    task automatic driveFrame(input logic [7:0] b, input bit badStop, input bit badPar);
        @(negedge clk);
        rxdDrive = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxdDrive = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef SPART_PARITY_EN
        rxdDrive = (^b) ^ badPar;
        repeat (BIT_CLKS) @(negedge clk);
`else
        if (badPar) rxdDrive = 1'b1;
`endif
        rxdDrive = !badStop;
        repeat (BIT_CLKS) @(negedge clk);
        rxdDrive = 1'b1;
    endtask

    logic [7:0]  d;
    logic [7:0]  b;
    logic [10:0] a5Seq;
    int          n;
    int          lowLen;

    initial begin
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        compareOn = 1'b1;

        // Reset values.
        busRead(2'b01, d); checkOutput("resetStatus", d, 8'h01);
        busRead(2'b10, d); checkOutput("resetDbl", d, 8'h12);
        busRead(2'b11, d); checkOutput("resetDbh", d, 8'h04);
        busRead(2'b00, d); checkOutput("resetRxBuf", d, 8'h00);
        checkOutput("resetTxd", txd, 1'b1);
        checkOutput("resetRda", rda, 1'b0);

        // Status writes are ignored.
        applyStimulus(2'b01, 8'hFF);
        busRead(2'b01, d); checkOutput("statusWriteIgnored", d, 8'h01);

        // Divisor 3 -> tick every 4 clocks, bit = 64 clocks.
        applyStimulus(2'b11, 8'h00);
        applyStimulus(2'b10, 8'h03);
        repeat (1100) @(negedge clk);
        busRead(2'b10, d); checkOutput("dblWritten", d, 8'h03);

        // A5 transmit, pinned against a hand-written bit sequence.
`ifdef SPART_PARITY_EN
        a5Seq = 11'b101_0100_1010;
`else
        a5Seq = 11'b011_0100_1010;
`endif
        applyStimulus(2'b00, 8'hA5);
        checkOutput("tbrFallNextCycle", tbr, 1'b0);
        n = 0;
        while (txd !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        checkOutput("startBitSeen", txd, 1'b0);
        lowLen = 0;
        while (txd === 1'b0 && lowLen < 200) begin @(negedge clk); lowLen++; end
        checkOutput("startBitLen", lowLen, 64);
        for (int i = 1; i < FRAME_BITS; i++) begin
            repeat (32) @(negedge clk);
            checkOutput($sformatf("a5Bit%0d", i), txd, a5Seq[i]);
            repeat (32) @(negedge clk);
        end
        waitTbrHigh(2000);

        // Random transmit through loopback, with ignored writes while busy.
        loopBack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            applyStimulus(2'b00, b);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(10, 300)) @(negedge clk);
                applyStimulus(2'b00, ~b);
            end
            waitTbrHigh(3000);
            busRead(2'b01, d); checkOutput("loopStatus", d, 8'h03);
            busRead(2'b00, d); checkOutput("loopByte", d, {24'h0, b});
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        // Loopback of 3C: rda set, read returns byte, rda falls on the read edge.
        applyStimulus(2'b00, 8'h3C);
        waitTbrHigh(3000);
        checkOutput("loop3cRda", rda, 1'b1);
        busRead(2'b00, d); checkOutput("loop3cByte", d, 8'h3C);
        checkOutput("loop3cRdaCleared", rda, 1'b0);
        loopBack = 1'b0;
        repeat (10) @(negedge clk);

        // Random receive frames.
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            driveFrame(b, 1'b0, 1'b0);
            repeat (10) @(negedge clk);
            busRead(2'b01, d); checkOutput("rxStatus", d, 8'h03);
            busRead(2'b00, d); checkOutput("rxByte", d, {24'h0, b});
        end

        // Overrun.
        driveFrame(8'h11, 1'b0, 1'b0);
        driveFrame(8'h22, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        busRead(2'b01, d); checkOutput("ovrStatus", d, 8'h0B);
        busRead(2'b01, d); checkOutput("ovrCleared", d, 8'h03);
        busRead(2'b00, d); checkOutput("ovrByte", d, 8'h22);
        busRead(2'b01, d); checkOutput("ovrFinalStatus", d, 8'h01);

        // Glitch: 5-clock low pulse is a false start.
        @(negedge clk); rxdDrive = 1'b0;
        repeat (5) @(negedge clk);
        rxdDrive = 1'b1;
        repeat (700) @(negedge clk);
        checkOutput("glitchNoRda", rda, 1'b0);
        busRead(2'b01, d); checkOutput("glitchStatus", d, 8'h01);

        // Framing error: byte still stored.
        driveFrame(8'h5A, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        busRead(2'b01, d); checkOutput("frmStatus", d, 8'h07);
        busRead(2'b00, d); checkOutput("frmByte", d, 8'h5A);
        busRead(2'b01, d); checkOutput("frmCleared", d, 8'h01);

`ifdef SPART_PARITY_EN
        // Flipped parity bit.
        driveFrame(8'h6B, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        busRead(2'b01, d); checkOutput("parStatus", d, 8'h13);
        busRead(2'b00, d); checkOutput("parByte", d, 8'h6B);
        busRead(2'b01, d); checkOutput("parCleared", d, 8'h01);
`endif

        // Reset in the middle of both a transmit and a receive frame.
        applyStimulus(2'b00, 8'hC3);
        @(negedge clk); rxdDrive = 1'b0;
        repeat (300) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midResetTbr", tbr, 1'b1);
        checkOutput("midResetTxd", txd, 1'b1);
        checkOutput("midResetRda", rda, 1'b0);
        rxdDrive = 1'b1;
        #2 rst = 1'b1;
        busRead(2'b01, d); checkOutput("postResetStatus", d, 8'h01);
        busRead(2'b10, d); checkOutput("postResetDbl", d, 8'h12);
        busRead(2'b00, d); checkOutput("postResetRxBuf", d, 8'h00);
        repeat (1500) @(negedge clk);
        checkOutput("postResetNoRda", rda, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
